// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between fetch and decode.
// Flush has priority over push and pop, and start_i low freezes all state.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   inst_i,
  input  logic          valid_i,
  output logic          stall_o,
  output logic [31:0]   pc_o,
  output logic [31:0]   inst_o,
  output logic          valid_o,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic [AW:0]   count_o
);

  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          flush;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign stall_o = full;
  assign valid_o = !empty;
  assign count_o = cnt;
  assign pc_o    = empty ? 32'h0 : mem[rp][63:32];
  assign inst_o  = empty ? 32'h0 : mem[rp][31:0];

  // Handshakes: fetch pushes when valid_i && !stall_o, and decode pops when
  // valid_o && !stall_i. Both are qualified by start_i and killed by a flush.
  assign flush = start_i & flush_i;
  assign push  = start_i & valid_i & !full & !flush_i;
  assign pop   = start_i & valid_o & !stall_i & !flush_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= {pc_i, inst_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rp  <= wp;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fall-through, full, wrap order,
// flush, freeze and asynchronous reset.
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        valid_i;
  logic        stall_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        stall_i;
  logic        flush_i;
  logic [2:0]  count_o;

  int vectors = 0;
  int miscompares = 0;

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .pc_i    (pc_i),
    .inst_i  (inst_i),
    .valid_i (valid_i),
    .stall_o (stall_o),
    .pc_o    (pc_o),
    .inst_o  (inst_o),
    .valid_o (valid_o),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] pc);
    valid_i = 1'b1;
    pc_i    = pc;
    inst_i  = 32'h1000_0000 | pc;
  endtask

  initial begin
    int model_cnt;
    int next_push;
    int next_pop;
    int cycles;
    rst_i = 1'b0; start_i = 1'b1; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    pc_i = 32'h0; inst_i = 32'h0;

    // Reset state
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Fall-through
    valid_i = 1'b1; pc_i = 32'h0; inst_i = 32'h8C01_0004;
    chk("ft_valid_before", 32'(valid_o), 32'd0);
    tick();
    chk("ft_valid", 32'(valid_o), 32'd1);
    chk("ft_pc", pc_o, 32'h0);
    chk("ft_inst", inst_o, 32'h8C01_0004);
    chk("ft_count", 32'(count_o), 32'd1);
    valid_i = 1'b0;
    tick();
    chk("ft_empty_valid", 32'(valid_o), 32'd0);
    chk("ft_empty_inst", inst_o, 32'h0);
    chk("ft_empty_count", 32'(count_o), 32'd0);

    // Fill to full
    stall_i = 1'b1;
    offer(32'h0); tick();
    offer(32'h4); tick();
    offer(32'h8); tick();
    chk("fill3_stall", 32'(stall_o), 32'd0);
    offer(32'hC); tick();
    chk("fill4_stall", 32'(stall_o), 32'd1);
    chk("fill4_count", 32'(count_o), 32'd4);
    chk("fill4_pc", pc_o, 32'h0);
    offer(32'h10); tick();
    chk("fill5_count", 32'(count_o), 32'd4);
    chk("fill5_pc", pc_o, 32'h0);
    chk("fill5_inst", inst_o, 32'h1000_0000);

    // Simultaneous push/pop at full: pop taken, push refused
    stall_i = 1'b0;
    tick();
    chk("pp_count", 32'(count_o), 32'd3);
    chk("pp_pc", pc_o, 32'h4);
    chk("pp_stall", 32'(stall_o), 32'd0);
    stall_i = 1'b1;
    tick();
    chk("pp2_count", 32'(count_o), 32'd4);
    chk("pp2_stall", 32'(stall_o), 32'd1);
    chk("pp2_pc", pc_o, 32'h4);
    valid_i = 1'b0; stall_i = 1'b0;
    tick(); chk("drain_pc8", pc_o, 32'h8);
    tick(); chk("drain_pcC", pc_o, 32'hC);
    tick(); chk("drain_pc10", pc_o, 32'h10);
    chk("drain_inst10", inst_o, 32'h1000_0010);
    tick();
    chk("drain_valid", 32'(valid_o), 32'd0);
    chk("drain_pc0", pc_o, 32'h0);

    // Streaming 16 entries with random decode stalls: order and wrap
    model_cnt = 0; next_push = 0; next_pop = 0; cycles = 0;
    while (next_pop < 16 && cycles < 300) begin
      stall_i = 1'($urandom_range(0, 1));
      if (next_push < 16) offer(32'(next_push * 4));
      else valid_i = 1'b0;
      chk("st_count", 32'(count_o), 32'(model_cnt));
      if (model_cnt > 0 && !stall_i) begin
        chk("st_pop_pc", pc_o, 32'(next_pop * 4));
        next_pop++;
        model_cnt--;
        if (next_push < 16 && model_cnt + 1 < 4) begin
          next_push++; model_cnt++;
        end
      end else if (next_push < 16 && model_cnt < 4) begin
        next_push++; model_cnt++;
      end
      tick();
      cycles++;
    end
    chk("st_all_popped", 32'(next_pop), 32'd16);
    valid_i = 1'b0; stall_i = 1'b0;
    tick();
    chk("st_final_empty", 32'(count_o), 32'd0);

    // Flush with a same-cycle fetch
    stall_i = 1'b1;
    offer(32'h100); tick();
    offer(32'h104); tick();
    offer(32'h108); tick();
    chk("fl_count3", 32'(count_o), 32'd3);
    offer(32'h40); flush_i = 1'b1;
    tick();
    chk("fl_count", 32'(count_o), 32'd0);
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_pc", pc_o, 32'h0);
    chk("fl_stall", 32'(stall_o), 32'd0);
    flush_i = 1'b0; valid_i = 1'b0;
    tick();
    chk("fl_not_enq", 32'(count_o), 32'd0);
    offer(32'h44); tick();
    chk("fl_new_pc", pc_o, 32'h44);
    chk("fl_new_count", 32'(count_o), 32'd1);
    valid_i = 1'b0; stall_i = 1'b0;
    tick();
    chk("fl_new_drain", 32'(count_o), 32'd0);

    // Freeze
    stall_i = 1'b1;
    offer(32'h200); tick();
    offer(32'h204); tick();
    start_i = 1'b0; stall_i = 1'b0; offer(32'h208);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fz_count", 32'(count_o), 32'd2);
      chk("fz_pc", pc_o, 32'h200);
    end
    start_i = 1'b1; valid_i = 1'b0; stall_i = 1'b1;

    // Asynchronous reset mid-cycle
    #2 rst_i = 1'b0;
    #1;
    chk("ar_valid", 32'(valid_o), 32'd0);
    chk("ar_count", 32'(count_o), 32'd0);
    chk("ar_pc", pc_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    offer(32'h300);
    tick();
    chk("ar_push_pc", pc_o, 32'h300);
    chk("ar_push_count", 32'(count_o), 32'd1);
    valid_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
